// File: rtl/load_store_buffer_pkg.sv
// rtl/load_store_buffer_pkg.sv - shared funct3 codes, memory length encodings and FSM states
package load_store_buffer_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsb_state_t;

  // The low two funct3 bits already are the access size code.
  function automatic logic [1:0] mem_len_of(logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/load_store_buffer_if.sv
// rtl/load_store_buffer_if.sv - memory controller request/response bus
interface load_store_buffer_if;

  logic        memFlag;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [1:0]  memLen;
  logic        memDone;
  logic [31:0] memValue;

  modport master (
    output memFlag, memWrite, memAddr, memData, memLen,
    input  memDone, memValue
  );

  modport slave (
    input  memFlag, memWrite, memAddr, memData, memLen,
    output memDone, memValue
  );

endinterface

// File: rtl/load_store_buffer_load_extender.sv
// rtl/load_store_buffer_load_extender.sv - sign/zero extension of raw load data by funct3
module load_extender
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    case (funct3)
      LB:      result = {{24{raw[7]}}, raw[7:0]};
      LH:      result = {{16{raw[15]}}, raw[15:0]};
      LW:      result = raw;
      LBU:     result = {24'b0, raw[7:0]};
      LHU:     result = {16'b0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - program-ordered load/store queue with in-order head execution
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int LSB_WIDTH = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clear,
  input  logic                 addFlag,
  input  logic                 addStore,
  input  logic [2:0]           addFunct3,
  input  logic [ROB_WIDTH-1:0] addRobId,
  input  logic [31:0]          addImm,
  input  logic                 addRs1Busy,
  input  logic                 addRs2Busy,
  input  logic [ROB_WIDTH-1:0] addRs1Id,
  input  logic [ROB_WIDTH-1:0] addRs2Id,
  input  logic [31:0]          addRs1Val,
  input  logic [31:0]          addRs2Val,
  output logic                 full,
  input  logic                 rsFlag,
  input  logic [ROB_WIDTH-1:0] rsId,
  input  logic [31:0]          rsValue,
  input  logic                 storeFlag,
  input  logic [ROB_WIDTH-1:0] storeId,
  output logic                 loadFlag,
  output logic [ROB_WIDTH-1:0] loadId,
  output logic [31:0]          loadValue,
  load_store_buffer_if.master  mem
);

  localparam int DEPTH = 1 << LSB_WIDTH;

  typedef logic [LSB_WIDTH-1:0] ptr_t;
  typedef logic [LSB_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic                 store;
    logic [2:0]           funct3;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          imm;
    logic                 rs1_busy;
    logic [ROB_WIDTH-1:0] rs1_id;
    logic [31:0]          rs1_val;
    logic                 rs2_busy;
    logic [ROB_WIDTH-1:0] rs2_id;
    logic [31:0]          rs2_val;
    logic                 committed;
  } entry_t;

  entry_t               ent  [DEPTH];
  entry_t               woke [DEPTH];
  entry_t               new_ent;
  entry_t               hd;
  ptr_t                 head, tail;
  cnt_t                 count, keep_cnt;
  logic [DEPTH-1:0]     valid;
  lsb_state_t           state;
  logic                 aborted;
  logic                 cur_store;
  logic [2:0]           cur_funct3;
  logic [ROB_WIDTH-1:0] cur_rob;
  logic                 mem_flag, mem_write;
  logic [31:0]          mem_addr, mem_data;
  logic [1:0]           mem_len;
  logic [31:0]          ext_value;
  logic                 dispatch, head_ready, pop, drop_head;

  assign full       = (count == cnt_t'(DEPTH));
  assign dispatch   = addFlag & ~full & readyIn & ~clear;
  assign hd         = ent[head];
  assign head_ready = (count != '0) && !hd.rs1_busy &&
                      (!hd.store || (!hd.rs2_busy && hd.committed));
  assign pop        = (state == BUSY) && mem.memDone && !aborted;
  // On clear the live head leaves the queue if it is a load (aborted) or a store finishing now.
  assign drop_head  = (state == BUSY) && !aborted && (!cur_store || mem.memDone);

  assign mem.memFlag  = mem_flag;
  assign mem.memWrite = mem_write;
  assign mem.memAddr  = mem_addr;
  assign mem.memData  = mem_data;
  assign mem.memLen   = mem_len;

  load_extender u_load_extender (
    .funct3 (cur_funct3),
    .raw    (mem.memValue),
    .result (ext_value)
  );

  always_comb begin
    valid    = '0;
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, ptr_t'(ptr_t'(i) - head)} < count;
      keep_cnt = keep_cnt + cnt_t'(valid[i] && ent[i].committed &&
                                   !(drop_head && (ptr_t'(i) == head)));
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent[i];
      if (ent[i].rs1_busy && rsFlag && rsId == ent[i].rs1_id) begin
        woke[i].rs1_busy = 1'b0;
        woke[i].rs1_val  = rsValue;
      end else if (ent[i].rs1_busy && loadFlag && loadId == ent[i].rs1_id) begin
        woke[i].rs1_busy = 1'b0;
        woke[i].rs1_val  = loadValue;
      end
      if (ent[i].rs2_busy && rsFlag && rsId == ent[i].rs2_id) begin
        woke[i].rs2_busy = 1'b0;
        woke[i].rs2_val  = rsValue;
      end else if (ent[i].rs2_busy && loadFlag && loadId == ent[i].rs2_id) begin
        woke[i].rs2_busy = 1'b0;
        woke[i].rs2_val  = loadValue;
      end
      if (storeFlag && valid[i] && ent[i].rob_id == storeId) begin
        woke[i].committed = 1'b1;
      end
    end
  end

  // Dispatching operands also catch a broadcast that lands in the same cycle.
  always_comb begin
    new_ent          = '0;
    new_ent.store    = addStore;
    new_ent.funct3   = addFunct3;
    new_ent.rob_id   = addRobId;
    new_ent.imm      = addImm;
    new_ent.rs1_id   = addRs1Id;
    new_ent.rs1_busy = addRs1Busy;
    new_ent.rs1_val  = addRs1Val;
    new_ent.rs2_id   = addRs2Id;
    new_ent.rs2_busy = addRs2Busy;
    new_ent.rs2_val  = addRs2Val;
    if (addRs1Busy && rsFlag && rsId == addRs1Id) begin
      new_ent.rs1_busy = 1'b0;
      new_ent.rs1_val  = rsValue;
    end else if (addRs1Busy && loadFlag && loadId == addRs1Id) begin
      new_ent.rs1_busy = 1'b0;
      new_ent.rs1_val  = loadValue;
    end
    if (addRs2Busy && rsFlag && rsId == addRs2Id) begin
      new_ent.rs2_busy = 1'b0;
      new_ent.rs2_val  = rsValue;
    end else if (addRs2Busy && loadFlag && loadId == addRs2Id) begin
      new_ent.rs2_busy = 1'b0;
      new_ent.rs2_val  = loadValue;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= IDLE;
      aborted    <= 1'b0;
      cur_store  <= 1'b0;
      cur_funct3 <= '0;
      cur_rob    <= '0;
      mem_flag   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_len    <= '0;
      loadFlag   <= 1'b0;
      loadId     <= '0;
      loadValue  <= '0;
    end else if (readyIn) begin
      if (clear) begin
        loadFlag <= 1'b0;
        head     <= head + ptr_t'(drop_head);
        tail     <= head + ptr_t'(drop_head) + keep_cnt[LSB_WIDTH-1:0];
        count    <= keep_cnt;
        if (state == BUSY && mem.memDone) begin
          state    <= IDLE;
          mem_flag <= 1'b0;
          aborted  <= 1'b0;
        end else if (drop_head) begin
          aborted <= 1'b1;
        end
      end else begin
        loadFlag <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          ent[i] <= woke[i];
        end
        if (dispatch) begin
          ent[tail] <= new_ent;
          tail      <= tail + ptr_t'(1);
        end
        if (pop) begin
          head <= head + ptr_t'(1);
        end
        count <= count + cnt_t'(dispatch) - cnt_t'(pop);
        case (state)
          IDLE: begin
            if (head_ready) begin
              state      <= BUSY;
              mem_flag   <= 1'b1;
              mem_write  <= hd.store;
              mem_addr   <= hd.rs1_val + hd.imm;
              mem_data   <= hd.rs2_val;
              mem_len    <= mem_len_of(hd.funct3);
              cur_store  <= hd.store;
              cur_funct3 <= hd.funct3;
              cur_rob    <= hd.rob_id;
            end
          end
          BUSY: begin
            if (mem.memDone) begin
              state    <= IDLE;
              mem_flag <= 1'b0;
              aborted  <= 1'b0;
              if (!aborted && !cur_store) begin
                loadFlag  <= 1'b1;
                loadId    <= cur_rob;
                loadValue <= ext_value;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/load_store_buffer.md
# load_store_buffer

Program-ordered load/store queue between the instruction unit and the memory controller, downstream of dispatch and alongside the reorder buffer. It:
- captures memory instructions at dispatch and resolves their operands from the result broadcasts;
- issues loads speculatively in order, and broadcasts load results back to the reorder buffer and reservation station;
- performs stores only after the reorder buffer commits them;
- on a misprediction clear, discards all uncommitted entries while draining committed stores.

## Interface
Parameters:
- LSB_WIDTH, 3, log2 of entry count (8 entries)
- ROB_WIDTH, 4, reorder-buffer tag width

Ports:
- clockIn  input  1  clock
- resetIn  input  1  synchronous, active-high reset
- readyIn  input  1  global enable; all state holds when low
- clear  input  1  misprediction flush from the reorder buffer
- addFlag  input  1  dispatch request
- addStore  input  1  1 = store, 0 = load
- addFunct3  input  3  width/sign code
- addRobId  input  ROB_WIDTH  destination reorder-buffer tag
- addImm  input  32  sign-extended offset
- addRs1Busy / addRs2Busy  input  1  operand pending
- addRs1Id / addRs2Id  input  ROB_WIDTH  producer tag when pending
- addRs1Val / addRs2Val  input  32  value when not pending (rs2 = store data)
- full  output  1  all entries occupied
- rsFlag / rsId / rsValue  input  1/ROB_WIDTH/32  ALU result broadcast
- storeFlag / storeId  input  1/ROB_WIDTH  store commit from the reorder buffer
- loadFlag / loadId / loadValue  output  1/ROB_WIDTH/32  load result broadcast
- memFlag  output  1  memory request, held until memDone
- memWrite  output  1  1 = store
- memAddr  output  32  byte address
- memData  output  32  store data
- memLen  output  2  0 = byte, 1 = half, 2 = word
- memDone  input  1  one-cycle completion pulse
- memValue  input  32  raw load data, zero-extended from memLen

## Operation
- Circular queue with head, tail and a count of LSB_WIDTH+1 bits. `full` = (count == 2^LSB_WIDTH).
- Each entry holds: store flag, funct3, robId, imm, two operand tags, two busy bits, two values, and a committed bit.
- Dispatch happens when addFlag & ~full & readyIn. Dispatch while full is ignored.
- Wakeup applies on rsFlag and on the block's own loadFlag. Every busy operand whose tag matches is set to the broadcast value and cleared busy.
- Dispatch bypass: a dispatching operand whose tag matches a same-cycle broadcast is captured as ready with the broadcast value.
- On storeFlag, the entry whose robId == storeId sets its committed bit.
- Only the head entry executes, and only when the FSM is IDLE.
- FSM states:
  - IDLE → BUSY when the head is valid, rs1 is ready, and it is either a load, or a store with rs2 ready and committed.
  - In IDLE → BUSY, the block drives memAddr = rs1Val + imm (32-bit wrap), memLen = funct3[1:0], memWrite, memData = rs2Val, and memFlag = 1.
  - BUSY → IDLE on memDone. memFlag drops and the head entry pops.
- Load result extension:
  - funct3 000: sign-extend bit 7.
  - funct3 001: sign-extend bit 15.
  - funct3 010: pass through.
  - funct3 100 / 101: zero-extend.
  - The extended value is registered onto loadValue, with loadFlag high for one cycle. Stores produce no broadcast.
- Clear (clear & readyIn):
  - Every entry without the committed bit is invalidated, and the tail is set to head + (number of committed entries). Committed stores are always a contiguous prefix from the head.
  - An in-flight load is aborted: its later memDone is consumed and no broadcast occurs.
  - An in-flight committed store completes normally.
  - Dispatch and wakeup in the clear cycle are ignored. loadFlag is forced to 0 in the cycle after a clear.

## Timing
- Reset values: loadFlag, loadId, loadValue, memFlag, memWrite, memAddr, memData and memLen are 0; full is 0; the queue is empty; the FSM is IDLE.
- Reset has priority over clear, and clear has priority over all else.
- A dispatched entry can issue no earlier than the cycle after dispatch.
- Load latency: memDone at cycle N → loadFlag at N+1.
- Pop and dispatch in the same cycle leave count unchanged. When full, a pop frees a slot that is visible (full=0) on the next cycle.
- Head and tail wrap modulo 2^LSB_WIDTH.
- A committed bit set in the same cycle the head is evaluated takes effect the next cycle.

## Structure
- The shared package holds the funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW), the memLen encodings, and the FSM state encodings IDLE and BUSY.
- One sub-module, `load_extender`: combinational funct3/raw-data → 32-bit result, reusable by the memory controller tests.

## Test plan
- LW with rs1 ready (0x100, imm 4), memValue 0xDEADBEEF → memAddr 0x104 and memLen 2; loadFlag with loadValue 0xDEADBEEF one cycle after memDone.
- LB (memValue 0x80) → loadValue 0xFFFFFF80; LBU on the same data → 0x00000080.
- SW with rs2 busy on tag 3:
  - rsFlag tag 3 value 0x55 arrives → memFlag stays 0.
  - storeFlag for its robId → memWrite=1, memData 0x55.
- Fill 8 entries → full=1 and a 9th dispatch is ignored; one pop → full=0 next cycle, and a new dispatch lands at wrapped index 0.
- Queue [committed SW, LW in flight, SB uncommitted], then clear → only the SW remains (count 1); the LW's memDone produces no loadFlag; the SW executes afterwards.
- resetIn asserted during BUSY → all outputs 0 next cycle and queue empty.
